// File: rtl/store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_result_monitor
// Description : Watches the core's store bus and reaches a sticky
//               PASS / FAIL / TIMEOUT verdict. It also keeps saturating
//               store and cycle counters and captures the last accepted
//               store for LEDs and debug.
//               Optional macro STORE_HIST_EN adds a 4-entry history of
//               accepted stores that is read through hist_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module store_result_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    // Must be >= 2 and must not exceed 2**CNT_W.
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    input  logic [1:0]       hist_sel,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      last_addr,
    output logic [31:0]      last_data,
    output logic [31:0]      hist_addr,
    output logic [31:0]      hist_data
);

    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PASS    = 2'd1,
        S_FAIL    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [31:0]      last_addr_q, last_addr_d;
    logic [31:0]      last_data_q, last_data_d;
    logic             w_accept;

    // A store is only accepted while the test is still running.
    assign w_accept = (state_q == S_RUN) && MemWrite;

    // Next-state and counter update; a store verdict outranks the timeout.
    always_comb begin
        state_d       = state_q;
        store_count_d = store_count_q;
        cycle_count_d = cycle_count_q;
        last_addr_d   = last_addr_q;
        last_data_d   = last_data_q;
        if (state_q == S_RUN) begin
            if (cycle_count_q != c_CNT_MAX) begin
                cycle_count_d = cycle_count_q + 1'b1;
            end
            if (MemWrite) begin
                if (store_count_q != c_CNT_MAX) begin
                    store_count_d = store_count_q + 1'b1;
                end
                last_addr_d = DataAdr;
                last_data_d = WriteData;
                if ((DataAdr == PASS_ADDR) && (WriteData == PASS_DATA)) begin
                    state_d = S_PASS;
                end else if (DataAdr != SCRATCH_ADDR) begin
                    state_d = S_FAIL;
                end else if (cycle_count_q == c_TO_LAST) begin
                    // Scratch store on the last allowed cycle still times out.
                    state_d = S_TIMEOUT;
                end
            end else if (cycle_count_q == c_TO_LAST) begin
                state_d = S_TIMEOUT;
            end
        end
    end

    // State, counter and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            store_count_q <= '0;
            cycle_count_q <= '0;
            last_addr_q   <= '0;
            last_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            store_count_q <= store_count_d;
            cycle_count_q <= cycle_count_d;
            last_addr_q   <= last_addr_d;
            last_data_q   <= last_data_d;
        end
    end

    assign done        = (state_q != S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timeout     = (state_q == S_TIMEOUT);
    assign store_count = store_count_q;
    assign cycle_count = cycle_count_q;
    assign last_addr   = last_addr_q;
    assign last_data   = last_data_q;

`ifdef STORE_HIST_EN
    logic [31:0] hist_addr_q [4];
    logic [31:0] hist_data_q [4];
    logic [1:0]  hist_wptr_q;
    logic [1:0]  w_rd_idx;

    // Circular history of accepted stores; the pointer wraps 3 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_addr_q[i] <= '0;
                hist_data_q[i] <= '0;
            end
            hist_wptr_q <= '0;
        end else if (w_accept) begin
            hist_addr_q[hist_wptr_q] <= DataAdr;
            hist_data_q[hist_wptr_q] <= WriteData;
            hist_wptr_q              <= hist_wptr_q + 2'd1;
        end
    end

    // hist_sel = 0 picks the newest entry; 2-bit arithmetic gives mod 4.
    assign w_rd_idx  = hist_wptr_q - 2'd1 - hist_sel;
    assign hist_addr = hist_addr_q[w_rd_idx];
    assign hist_data = hist_data_q[w_rd_idx];
`else
    logic w_unused_hist;

    assign w_unused_hist = ^{hist_sel, w_accept};
    assign hist_addr     = '0;
    assign hist_data     = '0;
`endif

endmodule
`default_nettype wire
